// File: rtl/fetch_stage_pkg.sv
// ============================================================================
//  Module   : fetch_stage_pkg
//  Purpose  : Shared run-control state encoding and instruction constants
//             for the IF stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } fetchState_t;

    localparam logic [31:0] c_NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] c_HALT_WORD = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_instruction_memory.sv
// ============================================================================
//  Module   : instruction_memory
//  Purpose  : Word-addressed instruction store with a synchronous write port
//             and a combinational read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_memory #(
    parameter int IMEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          writeEn,
    input  logic [$clog2(IMEM_DEPTH)-1:0] writeAddr,
    input  logic [31:0]                   writeData,
    input  logic [$clog2(IMEM_DEPTH)-1:0] readAddr,
    output logic [31:0]                   readData
);

    // Contents deliberately survive reset so a loaded program can be rerun.
    logic [31:0] r_mem [IMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (writeEn) begin
            r_mem[writeAddr] <= writeData;
        end
    end

    assign readData = r_mem[readAddr];

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : IF stage: PC register, loadable instruction memory, IF/ID latch
//             and IDLE/RUN/HALTED run control. Define FETCH_STEP_EN to add
//             single-step fetch control (StepMode/Step ports).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = c_HALT_WORD
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic                          PCWrite,
    input  logic                          IFIDWrite,
    input  logic                          Redirect,
    input  logic [31:0]                   RedirectPC,
    input  logic                          LoadWe,
    input  logic [$clog2(IMEM_DEPTH)-1:0] LoadAddr,
    input  logic [31:0]                   LoadData,
`ifdef FETCH_STEP_EN
    input  logic                          StepMode,
    input  logic                          Step,
`endif
    output logic [31:0]                   Instr_IFID,
    output logic [31:0]                   PCPlus4_IFID,
    output logic                          Valid_IFID,
    output logic [31:0]                   PC_Current,
    output logic                          Halted
);

    localparam int c_AW = $clog2(IMEM_DEPTH);

    fetchState_t r_state, w_stateNext;
    logic [31:0] r_pc, w_pcNext;
    logic [31:0] r_instr, w_instrNext;
    logic [31:0] r_pcPlus4, w_pcPlus4Next;
    logic        r_valid, w_validNext;

    logic [31:0] w_instr;
    logic [31:0] w_pcPlus4;
    logic        w_fetchEn;
    logic        w_memWe;

    assign w_pcPlus4 = r_pc + 32'd4;
    assign w_memWe   = LoadWe && (r_state != RUN);

`ifdef FETCH_STEP_EN
    assign w_fetchEn = !StepMode || Step;
`else
    assign w_fetchEn = 1'b1;
`endif

    instruction_memory #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk       (Clk),
        .writeEn   (w_memWe),
        .writeAddr (LoadAddr),
        .writeData (LoadData),
        .readAddr  (r_pc[c_AW+1:2]),
        .readData  (w_instr)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= c_NOP_WORD;
            r_pcPlus4 <= 32'h0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_pc      <= w_pcNext;
            r_instr   <= w_instrNext;
            r_pcPlus4 <= w_pcPlus4Next;
            r_valid   <= w_validNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_pcNext      = r_pc;
        w_instrNext   = r_instr;
        w_pcPlus4Next = r_pcPlus4;
        w_validNext   = r_valid;

        case (r_state)
            IDLE: begin
                w_instrNext   = c_NOP_WORD;
                w_pcPlus4Next = 32'h0;
                w_validNext   = 1'b0;
                if (Start) begin
                    w_stateNext = RUN;
                    w_pcNext    = RESET_PC;
                end
            end
            RUN: begin
                if (Redirect) begin
                    // A flush beats any stall and cancels a HALT being latched.
                    w_pcNext      = RedirectPC;
                    w_instrNext   = c_NOP_WORD;
                    w_pcPlus4Next = 32'h0;
                    w_validNext   = 1'b0;
                end else begin
                    if (PCWrite && w_fetchEn) begin
                        w_pcNext = w_pcPlus4;
                    end
                    if (IFIDWrite) begin
                        if (w_fetchEn) begin
                            w_instrNext   = w_instr;
                            w_pcPlus4Next = w_pcPlus4;
                            w_validNext   = 1'b1;
                            if (w_instr == HALT_WORD) begin
                                w_stateNext = HALTED;
                            end
                        end else begin
                            w_instrNext   = c_NOP_WORD;
                            w_pcPlus4Next = 32'h0;
                            w_validNext   = 1'b0;
                        end
                    end
                end
            end
            HALTED: begin
                if (IFIDWrite) begin
                    w_instrNext   = c_NOP_WORD;
                    w_pcPlus4Next = 32'h0;
                    w_validNext   = 1'b0;
                end
                if (Start) begin
                    w_stateNext = RUN;
                    w_pcNext    = RESET_PC;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign Instr_IFID   = r_instr;
    assign PCPlus4_IFID = r_pcPlus4;
    assign Valid_IFID   = r_valid;
    assign PC_Current   = r_pc;
    assign Halted       = (r_state == HALTED);

endmodule

`default_nettype wire
